// File: rtl/alu_operand_stage.sv
// RV32I ALU operand stage: decodes R/I/LUI/AUIPC operands into a two-entry
// (output register + skid register) FIFO. Define ALU_STAGE_SHAMT_CHECK_EN to flag malformed I-type shifts.
module alu_operand_stage (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iValid,
  output logic        oReady,
  input  logic [31:0] iInstr,
  input  logic [31:0] iRs1Data,
  input  logic [31:0] iRs2Data,
  input  logic [31:0] iPc,
  input  logic        iFlush,
  output logic        oValid,
  input  logic        iReady,
  output logic [31:0] oDataA,
  output logic [31:0] oDataB,
  output logic [2:0]  oFunct3,
  output logic [6:0]  oFunct7,
  output logic [4:0]  oRd,
  output logic        oIllegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        illegal;
  } opEntry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t   stateReg;
  state_t   stateNext;
  logic     readyReg;
  opEntry_t outReg;
  opEntry_t skidReg;
  opEntry_t decoded;
  logic     accept;
  logic     drain;
  logic     loadOut;
  logic     loadSkid;
  logic     moveSkid;
  logic     isShift;
  logic     unusedRs1Field;

  // rs1 index is resolved upstream; only its data is consumed here
  assign unusedRs1Field = ^iInstr[19:15];

  assign isShift = (iInstr[14:12] == 3'b001) || (iInstr[14:12] == 3'b101);

`ifdef ALU_STAGE_SHAMT_CHECK_EN
  logic badShift;
  assign badShift = iInstr[25]
                 || !((iInstr[31:25] == 7'b0000000) || (iInstr[31:25] == 7'b0100000))
                 || ((iInstr[31:25] == 7'b0100000) && (iInstr[14:12] == 3'b001));
`endif

  always_comb begin
    decoded    = '0;
    decoded.rd = iInstr[11:7];
    case (iInstr[6:0])
      OPC_OP: begin
        decoded.dataA  = iRs1Data;
        decoded.dataB  = iRs2Data;
        decoded.funct3 = iInstr[14:12];
        decoded.funct7 = iInstr[31:25];
      end
      OPC_OP_IMM: begin
        decoded.dataA  = iRs1Data;
        decoded.funct3 = iInstr[14:12];
        if (isShift) begin
          // bit 25 is dropped from funct7 so RV64-style shamt[5] cannot alias an opcode variant
          decoded.dataB  = {27'b0, iInstr[24:20]};
          decoded.funct7 = {iInstr[31:26], 1'b0};
`ifdef ALU_STAGE_SHAMT_CHECK_EN
          if (badShift) begin
            decoded.illegal = 1'b1;
            decoded.dataA   = '0;
            decoded.dataB   = '0;
          end
`endif
        end else begin
          decoded.dataB = {{20{iInstr[31]}}, iInstr[31:20]};
        end
      end
      OPC_LUI: begin
        decoded.dataB = {iInstr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        decoded.dataA = iPc;
        decoded.dataB = {iInstr[31:12], 12'b0};
      end
      default: begin
        decoded.illegal = 1'b1;
      end
    endcase
  end

  assign accept = iValid && readyReg;
  assign drain  = oValid && iReady;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stateReg <= EMPTY;
      readyReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      // ready is a registered view of the next state so the upstream sees it without a comb path
      readyReg <= (stateNext != TWO);
    end
  end

  always_comb begin
    stateNext = stateReg;
    if (iFlush) begin
      stateNext = EMPTY;
    end else begin
      case (stateReg)
        EMPTY: if (accept) stateNext = ONE;
        ONE: begin
          if (accept && !drain)      stateNext = TWO;
          else if (!accept && drain) stateNext = EMPTY;
        end
        TWO:     if (drain) stateNext = ONE;
        default: stateNext = EMPTY;
      endcase
    end
  end

  always_comb begin
    oValid   = (stateReg != EMPTY);
    loadOut  = 1'b0;
    loadSkid = 1'b0;
    moveSkid = 1'b0;
    if (!iFlush) begin
      case (stateReg)
        EMPTY: loadOut = accept;
        ONE: begin
          loadOut  = accept && drain;
          loadSkid = accept && !drain;
        end
        TWO:     moveSkid = drain;
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      outReg  <= '0;
      skidReg <= '0;
    end else begin
      if (loadOut)       outReg <= decoded;
      else if (moveSkid) outReg <= skidReg;
      if (loadSkid)      skidReg <= decoded;
    end
  end

  assign oReady   = readyReg;
  assign oDataA   = outReg.dataA;
  assign oDataB   = outReg.dataB;
  assign oFunct3  = outReg.funct3;
  assign oFunct7  = outReg.funct7;
  assign oRd      = outReg.rd;
  assign oIllegal = outReg.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: a queue model of capacity two plus a
// field-level operand decoder; honours ALU_STAGE_SHAMT_CHECK_EN like the design.
module tb_alu_operand_stage;

  logic        iClk;
  logic        iRst;
  logic        iValid;
  logic        oReady;
  logic [31:0] iInstr;
  logic [31:0] iRs1Data;
  logic [31:0] iRs2Data;
  logic [31:0] iPc;
  logic        iFlush;
  logic        oValid;
  logic        iReady;
  logic [31:0] oDataA;
  logic [31:0] oDataB;
  logic [2:0]  oFunct3;
  logic [6:0]  oFunct7;
  logic [4:0]  oRd;
  logic        oIllegal;

  alu_operand_stage dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
    .iInstr(iInstr), .iRs1Data(iRs1Data), .iRs2Data(iRs2Data), .iPc(iPc),
    .iFlush(iFlush), .oValid(oValid), .iReady(iReady),
    .oDataA(oDataA), .oDataB(oDataB), .oFunct3(oFunct3), .oFunct7(oFunct7),
    .oRd(oRd), .oIllegal(oIllegal)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        ill;
    logic [31:0] instr;
  } exp_t;

  exp_t sbQ[$];
  int   errors = 0;
  int   checks = 0;
  int   txnCount = 0;
  bit   pendingReset = 1'b1;

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Operand rules computed from the ISA fields with plain arithmetic
  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [31:0] pc);
    exp_t e;
    int unsigned op;
    int unsigned f3;
    int unsigned top;
    op    = instr % 128;
    f3    = (instr / 4096) % 8;
    top   = instr / 33554432;
    e.a   = 0; e.b = 0; e.f3 = 0; e.f7 = 0; e.ill = 0;
    e.rd  = 5'((instr / 128) % 32);
    e.instr = instr;
    if (op == 'h33) begin
      e.a = rs1; e.b = rs2; e.f3 = 3'(f3); e.f7 = 7'(top);
    end else if (op == 'h13) begin
      e.a = rs1; e.f3 = 3'(f3);
      if (f3 == 1 || f3 == 5) begin
        e.b  = (instr / 1048576) % 32;
        e.f7 = 7'(top - (top % 2));
`ifdef ALU_STAGE_SHAMT_CHECK_EN
        if (!(top == 0 || (top == 32 && f3 == 5))) begin
          e.ill = 1; e.a = 0; e.b = 0;
        end
`endif
      end else begin
        e.b = 32'($signed(instr) >>> 20);
      end
    end else if (op == 'h37) begin
      e.b = instr - (instr % 4096);
    end else if (op == 'h17) begin
      e.a = pc; e.b = instr - (instr % 4096);
    end else begin
      e.ill = 1;
    end
    return e;
  endfunction

  // Monitor: mid-cycle, predicts the transfers of the coming edge
  always @(negedge iClk) begin
    exp_t e;
    bit   expReady;
    if (iRst) begin
      chk("rstValid", 32'(oValid), 0);
      chk("rstReady", 32'(oReady), 0);
      chk("rstDataA", oDataA, 0);
      chk("rstDataB", oDataB, 0);
      chk("rstIllegal", 32'(oIllegal), 0);
      sbQ.delete();
      pendingReset = 1'b1;
    end else begin
      expReady = !pendingReset && (sbQ.size() < 2);
      chk("oReady", 32'(oReady), 32'(expReady));
      chk("oValid", 32'(oValid), 32'(sbQ.size() != 0));
      if (iFlush) begin
        sbQ.delete();
      end else begin
        if (sbQ.size() != 0 && iReady) begin
          e = sbQ.pop_front();
          txnCount++;
          chk("dataA", oDataA, e.a);
          chk("dataB", oDataB, e.b);
          chk("funct3", 32'(oFunct3), 32'(e.f3));
          chk("funct7", 32'(oFunct7), 32'(e.f7));
          chk("rd", 32'(oRd), 32'(e.rd));
          chk("illegal", 32'(oIllegal), 32'(e.ill));
          $display("txn %0d: instr=%h A=%h B=%h f3=%0d f7=%h rd=%0d ill=%0b",
                   txnCount, e.instr, oDataA, oDataB, oFunct3, oFunct7, oRd, oIllegal);
        end
        if (iValid && expReady) sbQ.push_back(model(iInstr, iRs1Data, iRs2Data, iPc));
      end
      pendingReset = 1'b0;
    end
  end

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] pc, input logic rdy,
                       input logic fl);
    @(posedge iClk);
    #1;
    iValid = v; iInstr = instr; iRs1Data = rs1; iRs2Data = rs2; iPc = pc;
    iReady = rdy; iFlush = fl;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, rdy, 1'b0);
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    int unsigned sel;
    w   = $urandom;
    sel = $urandom_range(0, 5);
    case (sel)
      0: w[6:0] = 7'h33;
      1, 2: begin
        w[6:0] = 7'h13;
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      3: w[6:0] = 7'h37;
      4: w[6:0] = 7'h17;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    iRst = 1'b1; iValid = 1'b0; iInstr = '0; iRs1Data = '0; iRs2Data = '0;
    iPc = '0; iFlush = 1'b0; iReady = 1'b0;
    @(posedge iClk);
    @(posedge iClk);
    #1 iRst = 1'b0;

    // ADD, SRAI, ADDI -1, LUI, AUIPC, unknown opcode, malformed shift
    drive(1'b1, 32'h002081B3, 32'hA, 32'h5, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h40435293, 32'h80000000, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'hFFF00093, 32'h1234, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h12345037, 32'hDEAD, 32'hBEEF, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'hABCDE117, 32'h1, 32'h2, 32'h00400010, 1'b1, 1'b0);
    drive(1'b1, 32'h0000A003, 32'h7, 32'h8, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h02009093, 32'h55, 32'h0, 32'h0, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Backpressure: three back-to-back valids while stalled
    drive(1'b1, 32'h00310233, 32'h11, 32'h22, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h00520313, 32'h33, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h00730393, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 3);

    // Flush while full, with a concurrent valid
    drive(1'b1, 32'h00100093, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h00200113, 32'h2, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h00300193, 32'h3, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(1'b1, 3);

    // Reset while two entries are held
    drive(1'b1, 32'h00400213, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h00500293, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(1'b0, 1);
    @(posedge iClk);
    #2 iRst = 1'b1;
    #1;
    chk("asyncRstValid", 32'(oValid), 0);
    chk("asyncRstReady", 32'(oReady), 0);
    chk("asyncRstDataB", oDataB, 0);
    @(posedge iClk);
    #1 iRst = 1'b0;
    iReady = 1'b1;
    idle(1'b1, 3);

    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, randInstr(), $urandom, $urandom, $urandom,
            ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0, ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
    end

    idle(1'b1, 4);
    @(negedge iClk);
    #1;
    chk("finalValid", 32'(oValid), 0);
    chk("finalReady", 32'(oReady), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-002 The module SHALL have port iClk, input, 1 bit: rising-edge clock.
REQ-003 The module SHALL have port iRst, input, 1 bit: asynchronous active-high reset.
REQ-004 The module SHALL have upstream ports: iValid (input, 1, instruction valid); oReady (output, 1, stage can accept); iInstr (input, 32, raw RV32I word); iRs1Data (input, 32); iRs2Data (input, 32); iPc (input, 32, instruction address).
REQ-005 The module SHALL have port iFlush, input, 1 bit: discard all held entries.
REQ-006 The module SHALL have downstream ports: oValid (output, 1); iReady (input, 1, ALU/EX accepts); oDataA (output, 32); oDataB (output, 32); oFunct3 (output, 3); oFunct7 (output, 7); oRd (output, 5); oIllegal (output, 1, unsupported encoding).

Function
REQ-007 The stage SHALL perform a transfer on each edge with both valid and ready high, on each side independently.
REQ-008 The stage SHALL present an accepted instruction on the outputs exactly 1 cycle after acceptance when empty.
REQ-009 The stage SHALL decode opcode 0110011 (R-type) as: A=iRs1Data, B=iRs2Data, funct3=iInstr[14:12], funct7=iInstr[31:25].
REQ-010 The stage SHALL decode opcode 0010011 (I-type): A=iRs1Data; funct3=iInstr[14:12]; shifts (funct3 001/101) B={27'b0,iInstr[24:20]}, funct7={iInstr[31:26],1'b0}; other funct3 B=sign-extended iInstr[31:20], funct7=0.
REQ-011 The stage SHALL decode LUI (0110111) as A=0, B={iInstr[31:12],12'b0}, funct3=000, funct7=0.
REQ-012 The stage SHALL decode AUIPC (0010111) as A=iPc, B={iInstr[31:12],12'b0}, funct3=000, funct7=0.
REQ-013 The stage SHALL pass other opcodes through with oIllegal=1, A=B=0, funct3=funct7=0; oRd=iInstr[11:7] always.
REQ-014 The stage SHALL buffer through an output register plus one skid register, with FSM EMPTY/ONE/TWO:
- EMPTY→ONE on accept.
- ONE→EMPTY on drain without accept; ONE stays on simultaneous accept+drain.
- ONE→TWO on accept without drain.
- TWO→ONE on drain: skid moves to the output register.
REQ-015 oReady SHALL be registered, high in EMPTY/ONE and low in TWO, so no input is lost when iReady drops.
REQ-016 Outputs SHALL hold stable while oValid=1 and iReady=0.
REQ-017 Ordering SHALL be strictly FIFO.
REQ-018 iFlush SHALL force EMPTY at the next edge, overriding any simultaneous accept or drain; the instruction presented on that edge is dropped.
REQ-019 oValid SHALL be low in EMPTY.

Reset
REQ-020 iRst SHALL immediately force EMPTY, oValid=0, oReady=0, and all data outputs and oIllegal to 0.
REQ-021 oReady SHALL rise on the first edge after iRst deasserts.
REQ-022 Reset mid-transfer SHALL discard both entries.

Configuration
REQ-023 With macro ALU_STAGE_SHAMT_CHECK_EN defined, an I-type shift with iInstr[25]=1, or with iInstr[31:25] not 0000000/0100000 (or 0100000 with funct3=001), SHALL set oIllegal=1 and A=B=0.
REQ-024 Without ALU_STAGE_SHAMT_CHECK_EN, those bits SHALL be ignored beyond REQ-010 and oIllegal SHALL be 0 for all 0010011 encodings.

Verification
REQ-025 ADD: iInstr=0x002081B3, rs1=0xA, rs2=0x5, iReady=1 -> next cycle oValid=1, A=0xA, B=0x5, funct3=000, funct7=0, rd=3.
REQ-026 SRAI: iInstr=0x40435293, rs1=0x80000000 -> A=0x80000000, B=0x4, funct3=101, funct7=0100000, rd=5.
REQ-027 ADDI -1: iInstr=0xFFF00093 -> B=0xFFFFFFFF, funct7=0, oIllegal=0; LUI 0x12345037 -> A=0, B=0x12345000.
REQ-028 Backpressure: iReady=0, three back-to-back valids -> first two accepted, oReady=0 after the second, outputs hold the first; iReady=1 -> both emerge in order and oReady returns high.
REQ-029 Flush in state TWO with a concurrent iValid -> next cycle oValid=0, oReady=1, no entry later emerges.
REQ-030 iInstr=0x02009093: with ALU_STAGE_SHAMT_CHECK_EN -> oIllegal=1, B=0; without it -> oIllegal=0, B=0, funct7=0.
